// File: rtl/pacman_map_writer.sv
// pacman_map_writer
// Read-modify-write initiator for the 64 x 80 Pac-Man map RAM. A clear request
// reads one map row, tests the addressed tile bit and writes the row back with
// that bit cleared if it was set. It also keeps the remaining-pellet count.
//
// Parameters:
//   READ_LAT     memory read latency (1 or 2 cycles) from the en/addr edge to mem_dout
//   PELLET_INIT  pellet count loaded at reset
//
// Ports:
//   clka, rstn            clock (rising edge), asynchronous active-low reset
//   clr_valid/x/y         clear request: tile column 0..79, row 0..63
//   clr_ready             high only while idle
//   mem_en/we/addr/din    RAM command port (all registered)
//   mem_dout              RAM read data, bit n = tile column n
//   done_valid            one-cycle pulse when a request finishes
//   eat_pulse             one-cycle pulse with done_valid when a pellet was present
//   bad_req               one-cycle pulse when a request has clr_x > 79
//   pellet_count          remaining pellets (saturates at 0)
//   all_clear             pellet_count == 0
module pacman_map_writer #(
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned PELLET_INIT = 240
) (
    input  logic        clka,
    input  logic        rstn,
    input  logic        clr_valid,
    input  logic [6:0]  clr_x,
    input  logic [5:0]  clr_y,
    output logic        clr_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [5:0]  mem_addr,
    output logic [79:0] mem_din,
    input  logic [79:0] mem_dout,
    output logic        done_valid,
    output logic        eat_pulse,
    output logic        bad_req,
    output logic [12:0] pellet_count,
    output logic        all_clear
);

    localparam logic [12:0] CntInit  = 13'(PELLET_INIT);
    localparam logic [1:0]  WaitLoad = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRd, StWait, StWr} state_e;

    state_e      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [6:0]  x_q;
    logic [5:0]  y_q;

    // Registered outputs and their next values.
    logic        ready_q, ready_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [5:0]  addr_q, addr_d;
    logic [79:0] din_q, din_d;
    logic        done_q, done_d;
    logic        eat_q, eat_d;
    logic        bad_q, bad_d;
    logic [12:0] cnt_q, cnt_d;

    logic        accept;
    logic        x_bad;
    logic        wait_last;
    logic        hit;
    logic [79:0] row_clr;

    assign accept    = (state_q == StIdle) && clr_valid;
    assign x_bad     = clr_x > 7'd79;
    assign wait_last = (state_q == StWait) && (wait_q == 2'd0);
    // x_q is only ever loaded with a legal column, so the index stays inside the row.
    assign hit       = mem_dout[x_q];
    assign row_clr   = mem_dout & ~(80'd1 << x_q);

    // State register.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (clr_valid && !x_bad) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                state_d = StWait;
                wait_d  = WaitLoad;
            end
            StWait: begin
                if (wait_q == 2'd0) begin
                    state_d = StWr;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StWr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: computes the value every registered output takes in the
    // cycle that follows, so the outputs line up with the state they belong to.
    always_comb begin
        ready_d = (state_d == StIdle);
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        eat_d   = 1'b0;
        bad_d   = accept && x_bad;
        cnt_d   = cnt_q;

        if (state_d == StRd) begin
            en_d   = 1'b1;
            addr_d = clr_y;
        end

        // Last WAIT cycle: the read row is on mem_dout, so decide and stage the write.
        if (wait_last) begin
            done_d = 1'b1;
            eat_d  = hit;
            if (hit) begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = y_q;
                din_d  = row_clr;
                if (cnt_q != 13'd0) begin
                    cnt_d = cnt_q - 13'd1;
                end
            end
        end
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 6'd0;
            din_q   <= 80'd0;
            done_q  <= 1'b0;
            eat_q   <= 1'b0;
            bad_q   <= 1'b0;
            cnt_q   <= CntInit;
        end else begin
            ready_q <= ready_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            eat_q   <= eat_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch; only loaded on a legal accept.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            x_q <= 7'd0;
            y_q <= 6'd0;
        end else if (accept && !x_bad) begin
            x_q <= clr_x;
            y_q <= clr_y;
        end
    end

    assign clr_ready    = ready_q;
    assign mem_en       = en_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_din      = din_q;
    assign done_valid   = done_q;
    assign eat_pulse    = eat_q;
    assign bad_req      = bad_q;
    assign pellet_count = cnt_q;
    assign all_clear    = (cnt_q == 13'd0);

endmodule
